// File: rtl/clock1_pkg.sv
// Shared types and constants for the front-panel key conditioner.
package clock1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_P,
        PRESSED,
        REPEAT,
        DEB_R
    } key_state_t;

    localparam logic [3:0] MODE_HHMM  = 4'b0000;
    localparam logic [3:0] MODE_MMSS  = 4'b0001;
    localparam logic [3:0] MODE_ALARM = 4'b0010;

    // Unreachable encodings fall back to HH:MM on the next step.
    function automatic logic [3:0] next_mode(input logic [3:0] cur);
        case (cur)
            MODE_HHMM: return MODE_MMSS;
            MODE_MMSS: return MODE_ALARM;
            default:   return MODE_HHMM;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, debounce/auto-repeat FSM and ms timer.
module key_debounce
    import clock1_pkg::*;
#(
    parameter int unsigned DEB_MS  = 20,
    parameter int unsigned HOLD_MS = 600,
    parameter int unsigned REP_MS  = 200,
    parameter bit          REP_EN  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    input  logic i_ms_tick,
    output logic o_pls,
    output logic o_held
);

    localparam int unsigned TMAX_A = (DEB_MS > HOLD_MS) ? DEB_MS : HOLD_MS;
    localparam int unsigned TMAX   = (TMAX_A > REP_MS) ? TMAX_A : REP_MS;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    logic [1:0]    r_sync;
    key_state_t    r_state;
    logic [TW-1:0] r_timer;
    logic          r_pls;
    logic          r_held;
    logic          w_key_s;
    logic [TW-1:0] w_timer_inc;

    assign w_key_s     = r_sync[1];
    assign w_timer_inc = r_timer + 1'b1;
    assign o_pls       = r_pls;
    assign o_held      = r_held;

    // A limit is reached on the ms tick whose incremented count equals it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_state <= IDLE;
            r_timer <= '0;
            r_pls   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_key};
            r_pls  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_key_s) begin
                        r_state <= DEB_P;
                        r_timer <= '0;
                    end
                end
                DEB_P: begin
                    if (!w_key_s) begin
                        r_state <= IDLE;
                    end else if (i_ms_tick) begin
                        if (w_timer_inc == TW'(DEB_MS)) begin
                            r_state <= PRESSED;
                            r_pls   <= 1'b1;
                            r_held  <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                end
                PRESSED: begin
                    if (!w_key_s) begin
                        r_state <= DEB_R;
                        r_timer <= '0;
                    end else if (REP_EN && i_ms_tick) begin
                        if (w_timer_inc == TW'(HOLD_MS)) begin
                            r_state <= REPEAT;
                            r_pls   <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (!w_key_s) begin
                        r_state <= DEB_R;
                        r_timer <= '0;
                    end else if (i_ms_tick) begin
                        if (w_timer_inc == TW'(REP_MS)) begin
                            r_pls   <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                end
                DEB_R: begin
                    // A bounce back to pressed resumes without a new pulse.
                    if (w_key_s) begin
                        r_state <= PRESSED;
                        r_timer <= '0;
                    end else if (i_ms_tick) begin
                        if (w_timer_inc == TW'(DEB_MS)) begin
                            r_state <= IDLE;
                            r_held  <= 1'b0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_adjust_ctrl.sv
// Front-panel key conditioner: ms timebase, three debounced keys,
// registered hour/minute adjust pulses and the display-mode register.
module key_adjust_ctrl
    import clock1_pkg::*;
#(
    parameter int unsigned MS_CYCLES = 50000,
    parameter int unsigned DEB_MS    = 20,
    parameter int unsigned HOLD_MS   = 600,
    parameter int unsigned REP_MS    = 200
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       KeyHr,
    input  logic       KeyMin,
    input  logic       KeyMode,
    output logic       AdjHr,
    output logic       AdjMin,
    output logic [2:0] Held,
    output logic [3:0] Mode
);

    localparam int unsigned MSW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

    logic [MSW-1:0] r_ms_cnt;
    logic           w_ms_tick;
    logic           w_pls_hr;
    logic           w_pls_min;
    logic           w_pls_mode;
    logic           w_held_hr;
    logic           w_held_min;
    logic           w_held_mode;
    logic           r_adj_hr;
    logic           r_adj_min;
    logic [3:0]     r_mode;

    assign w_ms_tick = (r_ms_cnt == MSW'(MS_CYCLES - 1));

    always_ff @(posedge CP) begin
        if (CR || w_ms_tick) begin
            r_ms_cnt <= '0;
        end else begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

    key_debounce #(
        .DEB_MS (DEB_MS),
        .HOLD_MS(HOLD_MS),
        .REP_MS (REP_MS),
        .REP_EN (1'b1)
    ) u_key_hr (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_key    (KeyHr),
        .i_ms_tick(w_ms_tick),
        .o_pls    (w_pls_hr),
        .o_held   (w_held_hr)
    );

    key_debounce #(
        .DEB_MS (DEB_MS),
        .HOLD_MS(HOLD_MS),
        .REP_MS (REP_MS),
        .REP_EN (1'b1)
    ) u_key_min (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_key    (KeyMin),
        .i_ms_tick(w_ms_tick),
        .o_pls    (w_pls_min),
        .o_held   (w_held_min)
    );

    key_debounce #(
        .DEB_MS (DEB_MS),
        .HOLD_MS(HOLD_MS),
        .REP_MS (REP_MS),
        .REP_EN (1'b0)
    ) u_key_mode (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_key    (KeyMode),
        .i_ms_tick(w_ms_tick),
        .o_pls    (w_pls_mode),
        .o_held   (w_held_mode)
    );

    always_ff @(posedge CP) begin
        if (CR) begin
            r_adj_hr  <= 1'b0;
            r_adj_min <= 1'b0;
            r_mode    <= MODE_HHMM;
        end else begin
            r_adj_hr  <= w_pls_hr;
            r_adj_min <= w_pls_min;
            if (w_pls_mode) begin
                r_mode <= next_mode(r_mode);
            end
        end
    end

    assign AdjHr  = r_adj_hr;
    assign AdjMin = r_adj_min;
    assign Held   = {w_held_mode, w_held_min, w_held_hr};
    assign Mode   = r_mode;

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Self-checking bench for key_adjust_ctrl: vector table, corner-case sequences
// and a randomized run against a tick-arithmetic reference model.
module tb_key_adjust_ctrl;

    localparam int MS   = 4;
    localparam int DEB  = 3;
    localparam int HOLD = 10;
    localparam int REP  = 5;
    localparam int N    = 1500;

    logic       CP = 1'b0;
    logic       CR;
    logic       KeyHr, KeyMin, KeyMode;
    logic       AdjHr, AdjMin;
    logic [2:0] Held;
    logic [3:0] Mode;

    int n_cmp = 0;
    int n_bad = 0;

    key_adjust_ctrl #(
        .MS_CYCLES(MS),
        .DEB_MS   (DEB),
        .HOLD_MS  (HOLD),
        .REP_MS   (REP)
    ) dut (
        .CP     (CP),
        .CR     (CR),
        .KeyHr  (KeyHr),
        .KeyMin (KeyMin),
        .KeyMode(KeyMode),
        .AdjHr  (AdjHr),
        .AdjMin (AdjMin),
        .Held   (Held),
        .Mode   (Mode)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic [2:0] keys;      // {mode, min, hr}
        int         hold;
        int         exp_hr;
        int         exp_min;
        logic [3:0] exp_mode;
    } vec_t;

    vec_t tbl [9];

    bit [2:0] raw    [0:N+64];
    bit [2:0] e_pls  [0:N+64];
    bit [2:0] e_held [0:N+64];

    int nh, nm, first, p1, p2, cnt, mc;
    bit found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_keys(input logic [2:0] k);
        {KeyMode, KeyMin, KeyHr} = k;
    endtask

    function automatic logic [3:0] mode_of(input int presses);
        case (presses % 3)
            0:       return 4'b0000;
            1:       return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    // Counter reads p mod MS after posedge p (p=0 is the last reset edge), so
    // the tick is consumed at edges that are multiples of MS. Returns the n-th
    // such edge strictly after edge e.
    function automatic int nth_tick(input int e, input int n);
        return ((e / MS) + 1) * MS + (n - 1) * MS;
    endfunction

    // Raw key sampled high on edges q..r-1. Debounce and repeat limits count
    // ticks seen after each state entry; adjust pulses and mode changes show
    // one edge after the FSM step, Held follows the FSM state directly.
    function automatic void model_press(input int k, input int q, input int r);
        int t1, t, d;
        t1 = nth_tick(q + 2, DEB);
        d  = nth_tick(r + 2, DEB);
        e_pls[t1 + 1][k] = 1'b1;
        for (int i = t1; i < d; i++) e_held[i][k] = 1'b1;
        if (k != 2) begin
            t = nth_tick(t1, HOLD);
            while (t <= r + 1) begin
                e_pls[t + 1][k] = 1'b1;
                t = nth_tick(t, REP);
            end
        end
    endfunction

    initial begin
        tbl[0] = '{3'b100, 60,  0, 0, 4'b0001};
        tbl[1] = '{3'b100, 60,  0, 0, 4'b0010};
        tbl[2] = '{3'b100, 60,  0, 0, 4'b0000};
        tbl[3] = '{3'b100, 60,  0, 0, 4'b0001};
        tbl[4] = '{3'b001, 30,  1, 0, 4'b0001};
        tbl[5] = '{3'b010, 100, 0, 4, 4'b0001};
        tbl[6] = '{3'b011, 60,  2, 2, 4'b0001};
        tbl[7] = '{3'b101, 60,  2, 0, 4'b0010};
        tbl[8] = '{3'b010, 8,   0, 0, 4'b0010};

        // Reset held while keys bounce
        CR = 1'b1;
        set_keys(3'b000);
        for (int i = 0; i < 3; i++) begin
            set_keys(3'($urandom));
            @(negedge CP);
            check("reset_outputs", {AdjHr, AdjMin, Held, Mode}, 9'd0);
        end
        CR = 1'b0;
        set_keys(3'b000);
        repeat (20) @(negedge CP);

        // Vector table: press for hold cycles, release, count pulses
        foreach (tbl[i]) begin
            nh = 0;
            nm = 0;
            set_keys(tbl[i].keys);
            for (int c = 0; c < tbl[i].hold + 40; c++) begin
                if (c == tbl[i].hold) set_keys(3'b000);
                @(negedge CP);
                nh += int'(AdjHr);
                nm += int'(AdjMin);
            end
            check($sformatf("tbl%0d_hr_pulses", i), nh, tbl[i].exp_hr);
            check($sformatf("tbl%0d_min_pulses", i), nm, tbl[i].exp_min);
            check($sformatf("tbl%0d_mode", i), Mode, tbl[i].exp_mode);
            check($sformatf("tbl%0d_held_released", i), Held, 3'b000);
        end

        // Bouncing hour key then a stable press
        nh = 0;
        first = -1;
        for (int c = 0; c < 20; c++) begin
            KeyHr = ((c / 2) % 2 == 0);
            @(negedge CP);
            nh += int'(AdjHr);
        end
        KeyHr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CP);
            if (AdjHr) begin
                nh++;
                if (first < 0) first = k;
            end
        end
        check("bounce_held_hr", Held[0], 1'b1);
        KeyHr = 1'b0;
        repeat (30) begin
            @(negedge CP);
            nh += int'(AdjHr);
        end
        check("bounce_pulse_count", nh, 1);
        // sync 2 + debounce DEB_MS ms with up to 1 ms tick-phase jitter + output register 1
        check("bounce_latency_window",
              (first >= 2 + (DEB - 1) * MS + 1) && (first <= 2 + (DEB + 1) * MS + 1), 1);

        // Hour and minute pressed in the same cycle
        found = 1'b0;
        set_keys(3'b011);
        for (int c = 0; c < 30; c++) begin
            @(negedge CP);
            if (!found && (AdjHr || AdjMin)) begin
                found = 1'b1;
                check("simul_pair", {AdjHr, AdjMin}, 2'b11);
            end
        end
        check("simul_seen", found, 1'b1);
        set_keys(3'b000);
        repeat (40) @(negedge CP);

        // Reset during minute auto-repeat with the key still held
        nm = 0;
        set_keys(3'b010);
        for (int c = 0; c < 200 && nm < 2; c++) begin
            @(negedge CP);
            nm += int'(AdjMin);
        end
        check("rst_prep_two_pulses", nm, 2);
        CR = 1'b1;
        @(negedge CP);
        check("rst_mid_repeat_clear", {AdjHr, AdjMin, Held, Mode}, 9'd0);
        CR = 1'b0;
        p1 = -1;
        p2 = -1;
        cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge CP);
            if (AdjMin) begin
                cnt++;
                if (p1 < 0) p1 = k;
                else if (p2 < 0) p2 = k;
            end
        end
        check("rst_redebounce_first", p1, nth_tick(3, DEB) + 1);
        check("rst_hold_second", p2, nth_tick(nth_tick(3, DEB), HOLD) + 1);
        check("rst_pulse_count", cnt, 2);
        set_keys(3'b000);
        repeat (40) @(negedge CP);

        // Randomized clean presses on all keys against the reference model
        for (int k = 0; k < 3; k++) begin
            int p, len, q, r;
            p = 1 + int'($urandom_range(0, 30));
            forever begin
                len = int'($urandom_range(16, (k == 2) ? 60 : 130));
                q = p;
                r = q + len;
                if (r > N - 40) break;
                for (int i = q; i < r; i++) raw[i][k] = 1'b1;
                model_press(k, q, r);
                p = r + int'($urandom_range(16, 40));
            end
        end
        CR = 1'b1;
        set_keys(3'b000);
        @(negedge CP);
        @(negedge CP);
        CR = 1'b0;
        set_keys(raw[1]);
        mc = 0;
        for (int p = 1; p <= N; p++) begin
            @(negedge CP);
            if (e_pls[p][2]) mc++;
            check($sformatf("rand_cyc%0d", p), {AdjHr, AdjMin, Held, Mode},
                  {e_pls[p][0], e_pls[p][1], e_held[p][2], e_held[p][1], e_held[p][0], mode_of(mc)});
            set_keys(raw[p + 1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
